// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: boot-time program loader for the MIPS32 core.
// Assembles an MSB-first byte stream into 32-bit instruction words, writes
// them to instruction memory from BASE_ADDR upward while holding the core
// halted, and releases the core with a one-cycle start strobe once the HLT
// word (32'hFC000000) has been written.
// Optional build macro MIPS32_LOADER_CHECKSUM_EN: after the HLT word, one
// trailer byte must bring the 8-bit byte sum to zero before the core starts.
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_halt_hold,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_checksum,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [31:0]       HLT_WORD = 32'hFC000000;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(MEM_DEPTH);

    // S_HLT_WR is the cycle in which the HLT word is written when there is
    // no checksum trailer to wait for; it keeps core_start one cycle behind
    // the final write.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HLT_WR,
        S_CHECK,
        S_START,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_ovf_q, err_ovf_d;
    logic              accept;
    logic              begin_load;
    logic [31:0]       word_full;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic [7:0]        sum_next;
    logic              err_ck_q, err_ck_d;
`endif

    assign in_ready  = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign accept    = in_valid & in_ready;
    assign word_full = {asm_q, in_data};
`ifdef MIPS32_LOADER_CHECKSUM_EN
    assign sum_next  = sum_q + in_data;
`endif

    // Next-state logic: byte assembly, word write scheduling, error detection
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        addr_d     = addr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        wdata_d    = wdata_q;
        err_ovf_d  = err_ovf_q;
        begin_load = 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_ck_d   = err_ck_q;
`endif

        // The address and count advance on the edge that ends a write cycle.
        if (we_q) begin
            addr_d  = addr_q + 1'b1;
            count_d = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                begin_load = 1'b1;
                if (start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    sum_d = sum_next;
`endif
                    if (byte_idx_q == 2'd3) begin
                        byte_idx_d = 2'd0;
                        if (count_q == DEPTH) begin
                            state_d   = S_ERR;
                            err_ovf_d = 1'b1;
                        end else begin
                            we_d    = 1'b1;
                            wdata_d = word_full;
                            if (word_full == HLT_WORD) begin
`ifdef MIPS32_LOADER_CHECKSUM_EN
                                state_d = S_CHECK;
`else
                                state_d = S_HLT_WR;
`endif
                            end
                        end
                    end else begin
                        asm_d      = {asm_q[15:0], in_data};
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            S_HLT_WR: begin
                state_d = S_START;
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (sum_next == 8'd0) begin
                        state_d = S_START;
                    end else begin
                        state_d  = S_ERR;
                        err_ck_d = 1'b1;
                    end
                end
            end
`endif
            S_START: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            S_ERR: begin
                if (start) begin
                    begin_load = 1'b1;
                    state_d    = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Every new load starts from a clean slate at BASE_ADDR.
        if (begin_load) begin
            byte_idx_d = 2'd0;
            addr_d     = BASE;
            count_d    = '0;
            err_ovf_d  = 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_d      = 8'd0;
            err_ck_d   = 1'b0;
`endif
        end
    end

    // State and datapath registers; reset aborts any load and holds the core
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            addr_q     <= BASE;
            count_q    <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            err_ovf_q  <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q      <= 8'd0;
            err_ck_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            asm_q      <= asm_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            err_ovf_q  <= err_ovf_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            err_ck_q   <= err_ck_d;
`endif
        end
    end

    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign word_count     = count_q;
    assign err_overflow   = err_ovf_q;
    assign core_start     = (state_q == S_START);
    assign core_halt_hold = (state_q != S_START) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign busy           = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                            (state_q == S_HLT_WR);
`ifdef MIPS32_LOADER_CHECKSUM_EN
    assign err_checksum   = err_ck_q;
`else
    assign err_checksum   = 1'b0;
`endif

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb_mips32_prog_loader: directed self-checking bench for mips32_prog_loader.
// Instance dut_a uses default parameters; dut_b uses MEM_DEPTH = 4 for the
// overflow case. Inputs change on the falling edge, outputs are sampled on
// the falling edge.
module tb_mips32_prog_loader;

    localparam logic [31:0] HLT = 32'hFC000000;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, core_halt_hold, core_start, busy, done;
    logic        err_overflow, err_checksum;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [10:0] word_count;

    logic        start_b, in_valid_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b, mem_we_b, core_halt_hold_b, core_start_b, busy_b, done_b;
    logic        err_overflow_b, err_checksum_b;
    logic [9:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [10:0] word_count_b;

    int assert_count = 0;
    int fail_count   = 0;
    int cycle_cnt    = 0;

    logic [9:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [9:0]  log_addr_b[$];
    logic [31:0] log_data_b[$];
    int          start_pulses, start_pulses_b;
    int          hlt_cycle, start_cycle, done_cycle;
    bit          done_seen;

    logic [31:0] prog [9] = '{32'h2801000A, 32'h28020014, 32'h28030019,
                              32'h0CE77800, 32'h0CE77800, 32'h00222000,
                              32'h0CE77800, 32'h00832800, 32'hFC000000};
    logic [31:0] prog_hlt [9] = '{32'hFC000000, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0};
    logic [7:0]  trailer;
    bit          use_trailer;

    mips32_prog_loader dut_a (
        .clk1(clk1), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_halt_hold(core_halt_hold), .core_start(core_start),
        .busy(busy), .done(done), .err_overflow(err_overflow),
        .err_checksum(err_checksum), .word_count(word_count)
    );

    mips32_prog_loader #(.MEM_DEPTH(4)) dut_b (
        .clk1(clk1), .rst_n(rst_n), .start(start_b), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .mem_we(mem_we_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .core_halt_hold(core_halt_hold_b), .core_start(core_start_b),
        .busy(busy_b), .done(done_b), .err_overflow(err_overflow_b),
        .err_checksum(err_checksum_b), .word_count(word_count_b)
    );

    // Free-running core clock
    always #5 clk1 = ~clk1;

    // Falling-edge monitor: logs every memory write and strobe timing
    always @(negedge clk1) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            if (mem_wdata == HLT) hlt_cycle = cycle_cnt;
        end
        if (core_start) begin
            start_pulses++;
            start_cycle = cycle_cnt;
        end
        if (done && !done_seen) begin
            done_seen  = 1'b1;
            done_cycle = cycle_cnt;
        end
        if (mem_we_b) begin
            log_addr_b.push_back(mem_addr_b);
            log_data_b.push_back(mem_wdata_b);
        end
        if (core_start_b) start_pulses_b++;
        cycle_cnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
        log_addr_b.delete();
        log_data_b.delete();
        start_pulses   = 0;
        start_pulses_b = 0;
        hlt_cycle      = -1;
        start_cycle    = -1;
        done_cycle     = -1;
        done_seen      = 1'b0;
    endtask

    // Called just after a falling edge; returns after the byte is taken
    task automatic sendByte(input bit sel_b, input logic [7:0] b);
        int t;
        t = 0;
        if (sel_b) begin
            in_valid_b = 1'b1;
            in_data_b  = b;
        end else begin
            in_valid = 1'b1;
            in_data  = b;
        end
        while (((sel_b ? in_ready_b : in_ready) !== 1'b1) && t < 50) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 50) checkOutput("ready_timeout", sel_b ? in_ready_b : in_ready, 1);
        @(negedge clk1);
    endtask

    task automatic pulseStart(input bit sel_b);
        @(negedge clk1);
        clearLog();
        if (sel_b) start_b = 1'b1; else start = 1'b1;
        @(negedge clk1);
        start_b = 1'b0;
        start   = 1'b0;
    endtask

    task automatic applyStimulus(input bit sel_b, input logic [31:0] words [9],
                                 input int nwords, input bit toggle,
                                 input int start_word, input bit check_progress,
                                 input bit send_trailer, input logic [7:0] tr);
        logic [7:0] b;
        for (int w = 0; w < nwords; w++) begin
            for (int j = 0; j < 4; j++) begin
                b = words[w][31-8*j -: 8];
                if (w == start_word && j == 0) start = 1'b1;
                sendByte(sel_b, b);
                start = 1'b0;
                if (check_progress && j != 3)
                    checkOutput($sformatf("pending_w%0d_b%0d", w, j), log_addr.size(), w);
                if (toggle) begin
                    in_valid   = 1'b0;
                    in_valid_b = 1'b0;
                    @(negedge clk1);
                end
            end
        end
        if (send_trailer) sendByte(sel_b, tr);
        in_valid   = 1'b0;
        in_valid_b = 1'b0;
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 100) checkOutput("done_timeout", done, 1);
        repeat (3) @(negedge clk1);
    endtask

    task automatic checkProgram(input string tag);
        checkOutput({tag, "_nwrites"}, log_addr.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < log_addr.size()) begin
                checkOutput($sformatf("%s_addr%0d", tag, i), log_addr[i], i);
                checkOutput($sformatf("%s_data%0d", tag, i), log_data[i], prog[i]);
            end
        end
        checkOutput({tag, "_word_count"}, word_count, 9);
        checkOutput({tag, "_start_pulses"}, start_pulses, 1);
        checkOutput({tag, "_done"}, done, 1);
        checkOutput({tag, "_halt"}, core_halt_hold, 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_halt"}, core_halt_hold, 1);
        checkOutput({tag, "_in_ready"}, in_ready, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_core_start"}, core_start, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err_ovf"}, err_overflow, 0);
        checkOutput({tag, "_err_ck"}, err_checksum, 0);
        checkOutput({tag, "_word_count"}, word_count, 0);
    endtask

    // Main directed sequence
    initial begin
        int n_before;
        logic [7:0] s;
        rst_n      = 1'b0;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        start_b    = 1'b0;
        in_valid_b = 1'b0;
        in_data_b  = 8'h00;
        clearLog();

        // Checksum trailer: two's complement of the byte sum of the program
        s = 8'h00;
        for (int w = 0; w < 9; w++)
            for (int j = 0; j < 4; j++)
                s = s + prog[w][31-8*j -: 8];
        trailer = 8'h00 - s;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        use_trailer = 1'b1;
`else
        use_trailer = 1'b0;
`endif

        repeat (3) @(negedge clk1);
        checkResetState("reset");
        checkOutput("reset_b_halt", core_halt_hold_b, 1);
        rst_n = 1'b1;

        $display("[TB] full program, in_valid held high");
        pulseStart(0);
        applyStimulus(0, prog, 9, 0, -1, 0, use_trailer, trailer);
        waitDone();
        checkProgram("held");
        checkOutput("held_start_after_hlt", start_cycle, hlt_cycle + 1);
        checkOutput("held_done_after_start", done_cycle, start_cycle + 1);

        $display("[TB] restart from DONE, toggled in_valid, start during LOAD");
        pulseStart(0);
        checkOutput("restart_halt", core_halt_hold, 1);
        checkOutput("restart_busy", busy, 1);
        checkOutput("restart_done", done, 0);
        checkOutput("restart_addr", mem_addr, 0);
        checkOutput("restart_word_count", word_count, 0);
        applyStimulus(0, prog, 9, 1, 4, 1, use_trailer, trailer);
        waitDone();
        checkProgram("toggle");

        $display("[TB] reset after 18 bytes");
        pulseStart(0);
        for (int k = 0; k < 18; k++) sendByte(0, prog[k/4][31-8*(k%4) -: 8]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetState("midreset");
        n_before = log_addr.size();
        checkOutput("midreset_writes", n_before, 4);
        repeat (4) @(negedge clk1);
        checkOutput("midreset_no_more_writes", log_addr.size(), n_before);
        checkOutput("midreset_halt_held", core_halt_hold, 1);
        rst_n = 1'b1;
        pulseStart(0);
        applyStimulus(0, prog, 9, 0, -1, 0, use_trailer, trailer);
        waitDone();
        checkProgram("reload");

        $display("[TB] overflow with MEM_DEPTH = 4");
        pulseStart(1);
        applyStimulus(1, prog, 5, 0, -1, 0, 0, 8'h00);
        repeat (4) @(negedge clk1);
        checkOutput("ovf_nwrites", log_addr_b.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_addr_b.size()) begin
                checkOutput($sformatf("ovf_addr%0d", i), log_addr_b[i], i);
                checkOutput($sformatf("ovf_data%0d", i), log_data_b[i], prog[i]);
            end
        end
        checkOutput("ovf_flag", err_overflow_b, 1);
        checkOutput("ovf_halt", core_halt_hold_b, 1);
        checkOutput("ovf_start_pulses", start_pulses_b, 0);
        checkOutput("ovf_in_ready", in_ready_b, 0);
        checkOutput("ovf_done", done_b, 0);
        checkOutput("ovf_word_count", word_count_b, 4);
        pulseStart(1);
        checkOutput("ovf_cleared_by_start", err_overflow_b, 0);
        checkOutput("ovf_restart_busy", busy_b, 1);

`ifdef MIPS32_LOADER_CHECKSUM_EN
        $display("[TB] checksum trailer good and bad");
        pulseStart(0);
        applyStimulus(0, prog_hlt, 1, 0, -1, 0, 1, 8'h04);
        waitDone();
        checkOutput("ck_good_done", done, 1);
        checkOutput("ck_good_err", err_checksum, 0);
        checkOutput("ck_good_start_pulses", start_pulses, 1);
        pulseStart(0);
        applyStimulus(0, prog_hlt, 1, 0, -1, 0, 1, 8'h05);
        repeat (4) @(negedge clk1);
        checkOutput("ck_bad_err", err_checksum, 1);
        checkOutput("ck_bad_halt", core_halt_hold, 1);
        checkOutput("ck_bad_done", done, 0);
        checkOutput("ck_bad_start_pulses", start_pulses, 0);
`endif

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Upstream boot stage for the MIPS32 core.
- Accepts a byte stream over a valid/ready interface and assembles 32-bit instruction words, MSB first.
- Writes each word into the core's instruction memory at sequential addresses, holding the core halted while it does so.
- On receiving the HLT word (32'hFC000000), writes it, releases the core and pulses a start strobe so the core begins fetching at PC 0.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- MEM_DEPTH, 1024, number of writable words; must be ≤ 2**ADDR_W.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk1  input  1  core phase-1 clock; the only clock of this block.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a load; honoured in IDLE, DONE, ERR only.
- in_valid  input  1  byte-stream valid.
- in_data  input  8  byte-stream data.
- in_ready  output  1  byte-stream ready.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_W  instruction-memory write address.
- mem_wdata  output  32  instruction-memory write data.
- core_halt_hold  output  1  drives the core's HALTED; 1 holds the core.
- core_start  output  1  one-cycle pulse; the core clears PC and TAKEN_BRANCH and runs.
- busy  output  1  high in LOAD/CHECK.
- done  output  1  high in DONE.
- err_overflow  output  1  program exceeded MEM_DEPTH.
- err_checksum  output  1  checksum mismatch; tied 0 when the feature is off.
- word_count  output  ADDR_W+1  words written in the current or last load.

Behaviour:
- Reset values:
  - core_halt_hold = 1.
  - All other outputs = 0.
  - state = IDLE; byte index = 0; address = BASE_ADDR.
  - Reset asserted mid-load aborts immediately: no further writes, and the core stays held.
- Handshake:
  - A byte transfers on a rising clk1 edge where in_valid & in_ready.
  - in_ready = 1 only in LOAD and CHECK.
  - The block never stalls inside LOAD.
- State IDLE:
  - start → LOAD.
  - Clears word_count, byte index, the error flags and the checksum accumulator.
  - Sets address = BASE_ADDR.
  - core_halt_hold = 1.
- State LOAD:
  - Each accepted byte shifts into an assembly register, MSB first.
  - The accepted byte is added to the 8-bit running sum, mod 256.
  - If the 4th byte is accepted at edge N:
    - cycle N+1: mem_we = 1, mem_addr = current address, mem_wdata = the assembled word.
    - Address and word_count increment at edge N+1.
  - A completed word equal to 32'hFC000000 is written like any other word, then:
    - → CHECK if the feature is compiled in;
    - otherwise → START.
  - A word that completes while word_count == MEM_DEPTH:
    - is not written (no mem_we);
    - → ERR with err_overflow = 1.
  - start is ignored in LOAD and CHECK.
- State START (one cycle):
  - core_start = 1.
  - core_halt_hold falls to 0 in this cycle.
  - → DONE.
- State DONE:
  - done = 1; core_halt_hold = 0.
  - start → LOAD: core_halt_hold returns to 1 at the same edge, and the new load begins.
- State ERR:
  - Error flag held; core_halt_hold = 1; in_ready = 0.
  - start → LOAD, clearing the flags.
- Timing: if the HLT word's mem_we is in cycle C:
  - core_start = 1 in cycle C+1;
  - done = 1 from cycle C+2.
- Boundaries:
  - A partial word (1–3 bytes) with no further input stays pending indefinitely.
  - Address does not wrap; overflow is the only exit once MEM_DEPTH is reached.
  - in_valid while in_ready = 0 is ignored; those bytes are not consumed.

Optional Feature:
- Macro: MIPS32_LOADER_CHECKSUM_EN.
- Defined:
  - After the HLT write, state CHECK accepts exactly one byte.
  - If that byte equals the two's-complement negation of the 8-bit sum of all preceding bytes (including the HLT bytes), the total is 0 mod 256 → START.
  - Otherwise → ERR with err_checksum = 1.
  - core_halt_hold stays 1 throughout CHECK.
- Undefined: CHECK does not exist and err_checksum is constant 0.

Test Plan:
- Load 2801000A 28020014 28030019 0CE77800 0CE77800 00222000 0CE77800 00832800 FC000000 as 36 bytes, with in_valid held high → 9 writes at addr 0..8 with exactly those words, word_count = 9, core_start a single pulse one cycle after the addr-8 write, done = 1, core_halt_hold = 0.
- Same stream, in_valid toggled 1-0-1-0 → identical write sequence; no write occurs before the 4th accepted byte of each word.
- MEM_DEPTH = 4, stream of 5 non-HLT words → 4 writes at addr 0..3, no 5th write, err_overflow = 1, core_halt_hold = 1, core_start never pulses.
- Reset pulse after 18 bytes of a load → all outputs at reset values; a following start plus the full stream reloads from addr 0 correctly.
- start asserted during LOAD → ignored; start in DONE → core_halt_hold = 1 at that edge and a new load begins at BASE_ADDR.
- With checksum enabled:
  - bytes FC 00 00 00 plus trailer 04 → START, done = 1;
  - trailer 05 → err_checksum = 1, core held.
